regfile_wb_queue: RTL and testbench

Write-back queue in front of the 16-bit register file's single write port. Accepts register-write requests from the execute stage and holds up to DEPTH of them in order. Drains one per cycle onto the register file write port (`cw`/`w`/`data`) whenever the port is granted. An optional forwarding path lets the operand-read stage see queued, not-yet-written values for the two read addresses.

---
 rtl/regfile_wb_queue.sv | 132 +++++++++++++
 tb/tb_regfile_wb_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back queue in front of the register file's single write port.
//
// Execute-stage write requests are buffered in a DEPTH-entry circular buffer. One entry is
// written to the register file each cycle that the write port is granted (drain).
//
// Optional feature: define WBQ_FWD_EN to build the forwarding comparators. These report the
// youngest queued value for the two operand-read addresses. When it is undefined, the q*_hit
// and q*_data outputs are tied to zero.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready == !full)
//   in_addr/in_data      destination register and value
//   drain                register file write port granted this cycle
//   wr_en/wr_addr/wr_data  register file cw/w/data (head entry)
//   count/full/empty     occupancy status, registered-state only
//   q1_addr/q2_addr      forwarding lookup addresses (r1/r2)
//   q1_hit/q2_hit        a queued entry targets that address
//   q1_data/q2_data      value of the youngest matching entry
module regfile_wb_queue #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic [AW-1:0]            q1_addr,
  input  logic [AW-1:0]            q2_addr,
  output logic                     q1_hit,
  output logic                     q2_hit,
  output logic [DW-1:0]            q1_data,
  output logic [DW-1:0]            q2_data
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;

  // No fall-through: an entry pushed into an empty queue is drained next cycle at the earliest.
  assign wr_en   = drain && !empty && !rst;
  assign pop     = wr_en;
  assign push    = in_valid && in_ready && !rst;
  assign wr_addr = addr_mem[head_q];
  assign wr_data = data_mem[head_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
    end
  end

`ifdef WBQ_FWD_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    q1_hit  = 1'b0;
    q2_hit  = 1'b0;
    q1_data = '0;
    q2_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_mem[idx] == q1_addr) begin
          q1_hit  = 1'b1;
          q1_data = data_mem[idx];
        end
        if (addr_mem[idx] == q2_addr) begin
          q2_hit  = 1'b1;
          q2_data = data_mem[idx];
        end
      end
    end
  end
`else
  logic unused_qaddr;

  assign unused_qaddr = ^{q1_addr, q2_addr};
  assign q1_hit  = 1'b0;
  assign q2_hit  = 1'b0;
  assign q1_data = '0;
  assign q2_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_addr;
  logic [15:0] in_data;
  logic        drain;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] q1_addr, q2_addr;
  logic        q1_hit, q2_hit;
  logic [15:0] q1_data, q2_data;

  always #5 clk = ~clk;

  regfile_wb_queue #(.AW(16), .DW(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain    (drain),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .q1_addr  (q1_addr),
    .q2_addr  (q2_addr),
    .q1_hit   (q1_hit),
    .q2_hit   (q2_hit),
    .q1_data  (q1_data),
    .q2_data  (q2_data)
  );

  // Reference model: an ordered list of pending writes.
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ent_t;
  ent_t mq[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model; called at negedge with inputs settled.
  task automatic check_model();
    logic        e_wr;
    logic        h1, h2;
    logic [15:0] d1, d2;
    e_wr = drain && (mq.size() > 0) && !rst;
    check("wr_en", wr_en, e_wr);
    if (e_wr) begin
      check("wr_addr", wr_addr, mq[0].a);
      check("wr_data", wr_data, mq[0].d);
    end
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("in_ready", in_ready, mq.size() != DEPTH);
    h1 = 0; h2 = 0; d1 = 0; d2 = 0;
`ifdef WBQ_FWD_EN
    foreach (mq[i]) begin
      if (mq[i].a == q1_addr) begin h1 = 1; d1 = mq[i].d; end
      if (mq[i].a == q2_addr) begin h2 = 1; d2 = mq[i].d; end
    end
`endif
    check("q1_hit", q1_hit, h1);
    check("q1_data", q1_data, d1);
    check("q2_hit", q2_hit, h2);
    check("q2_data", q2_data, d2);
  endtask

  // Drive one cycle's inputs, check at negedge, then advance past the posedge.
  task automatic apply(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic dr, input logic r);
    in_valid = v; in_addr = a; in_data = d; drain = dr; rst = r;
    @(negedge clk);
    check_model();
  endtask

  task automatic commit();
    logic do_pop, do_push;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      do_pop  = drain && (mq.size() > 0);
      do_push = in_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{a: in_addr, d: in_data});
    end
    #1;
  endtask

  task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] d,
                       input logic dr, input logic r);
    apply(v, a, d, dr, r);
    commit();
  endtask

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [15:0] d;
    logic        dr;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    int          e_cnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 16'h0001, 16'h0001, 0, 0, 16'h0, 16'h0, 0};
    tbl[1] = '{1, 16'h0002, 16'h1401, 0, 0, 16'h0, 16'h0, 1};
    tbl[2] = '{1, 16'h0003, 16'h0002, 0, 0, 16'h0, 16'h0, 2};
    tbl[3] = '{1, 16'h0004, 16'habcd, 0, 0, 16'h0, 16'h0, 3};
    tbl[4] = '{0, 16'h0000, 16'h0000, 0, 0, 16'h0, 16'h0, 4};
    tbl[5] = '{0, 16'h0000, 16'h0000, 1, 1, 16'h0001, 16'h0001, 4};
    tbl[6] = '{0, 16'h0000, 16'h0000, 1, 1, 16'h0002, 16'h1401, 3};
    tbl[7] = '{0, 16'h0000, 16'h0000, 1, 1, 16'h0003, 16'h0002, 2};
    tbl[8] = '{0, 16'h0000, 16'h0000, 1, 1, 16'h0004, 16'habcd, 1};
    tbl[9] = '{0, 16'h0000, 16'h0000, 0, 0, 16'h0, 16'h0, 0};

    in_valid = 0; in_addr = 0; in_data = 0; drain = 0; rst = 1;
    q1_addr = 16'h0005; q2_addr = 16'h0007;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();

    // Reset state
    cycle(0, 0, 0, 1, 0);

    // Fill and drain from the table
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].dr, 0);
      check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].e_wr);
      if (tbl[i].e_wr) begin
        check($sformatf("tbl%0d_wr_addr", i), wr_addr, tbl[i].e_addr);
        check($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].e_data);
      end
      check($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_full", i), full, tbl[i].e_cnt == DEPTH);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].e_cnt == 0);
      commit();
    end

    // Streaming: each write one cycle after its push, count never above 1
    for (int i = 0; i < 11; i++) begin
      apply(i < 10, 16'(i), 16'($urandom), 1, 0);
      check("stream_count_le1", count <= 1, 1);
      check("stream_wr_en", wr_en, i > 0);
      if (i > 0) check("stream_wr_addr", wr_addr, 16'(i - 1));
      commit();
    end

    // Full with simultaneous pop: no push that cycle, accepted the next
    for (int i = 0; i < 4; i++) cycle(1, 16'h0010 + 16'(i), 16'($urandom), 0, 0);
    apply(1, 16'h0020, 16'h2020, 1, 0);
    check("fullpop_in_ready", in_ready, 0);
    commit();
    check("fullpop_count", count, 3);
    apply(1, 16'h0021, 16'h2121, 0, 0);
    check("fullpop_next_ready", in_ready, 1);
    commit();
    check("fullpop_count_after", count, 4);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);

    // Forwarding: youngest of two matching entries
    q1_addr = 16'h0005; q2_addr = 16'h0007;
    cycle(1, 16'h0005, 16'h0aac, 0, 0);
    cycle(1, 16'h0005, 16'h1111, 0, 0);
    apply(0, 0, 0, 0, 0);
`ifdef WBQ_FWD_EN
    check("fwd_q1_hit", q1_hit, 1);
    check("fwd_q1_data", q1_data, 16'h1111);
`else
    check("fwd_q1_hit", q1_hit, 0);
`endif
    check("fwd_q2_hit", q2_hit, 0);
    commit();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

    // Reset mid-operation with drain asserted
    for (int i = 0; i < 3; i++) cycle(1, 16'h0030 + 16'(i), 16'($urandom), 0, 0);
    apply(0, 0, 0, 1, 1);
    check("rst_wr_en", wr_en, 0);
    commit();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 0, 1, 0);
      check("post_rst_wr_en", wr_en, 0);
      check("post_rst_empty", empty, 1);
      commit();
    end

    // Wrap-around: alternate two pushes and two pops
    for (int r = 0; r < 5; r++) begin
      cycle(1, 16'h0100 + 16'(2 * r), 16'($urandom), 0, 0);
      cycle(1, 16'h0101 + 16'(2 * r), 16'($urandom), 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      q1_addr = 16'($urandom_range(0, 5));
      q2_addr = 16'($urandom_range(0, 5));
      cycle($urandom_range(0, 3) != 0, 16'($urandom_range(0, 5)), 16'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 60) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
